// File: rtl/gap_wall_pkg.sv
// Shared types and constants for the gap wall obstacle.
// Optional collision latch in gap_wall_gen is enabled by defining GAP_WALL_HIT_EN.
package gap_wall_pkg;

    // Motion state of the gap.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DOWN = 2'd1,
        UP   = 2'd2
    } state_t;

    // Active VGA playfield.
    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned V_ACTIVE = 480;

    // Default coordinate width (covers 0..1023).
    localparam int unsigned COORD_W_DEF = 10;

endpackage

// File: rtl/gap_motion_fsm.sv
// Gap motion: IDLE/DOWN/UP state register and the gap_y bounce counter.
// Bound arithmetic is one bit wider than the coordinates, so nothing wraps.
module gap_motion_fsm
    import gap_wall_pkg::*;
#(
    parameter int unsigned COORD_W   = COORD_W_DEF,
    parameter int unsigned Y_TOP     = 10,
    parameter int unsigned Y_BOT     = 470,
    parameter int unsigned GAP_START = 150,
    parameter int unsigned STEP      = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               start,
    input  logic               frame,
    input  logic               move_en,
    input  logic [COORD_W:0]   gap_len,
    output logic [COORD_W-1:0] gap_y,
    output logic               dir_up
);

    localparam int unsigned W = COORD_W + 1;

    state_t             state_q, state_d;
    logic [COORD_W-1:0] gap_y_q, gap_y_d;
    logic [W-1:0]       gap_ext;
    logic [W-1:0]       gap_bot;

    // State and gap position registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            gap_y_q <= COORD_W'(GAP_START);
        end else begin
            state_q <= state_d;
            gap_y_q <= gap_y_d;
        end
    end

    // Next state: load > start > frame; a gap that already overhangs the
    // bottom (after a gap_sel change) is pulled back flush to Y_BOT.
    always_comb begin
        state_d = state_q;
        gap_y_d = gap_y_q;
        gap_ext = {1'b0, gap_y_q};
        gap_bot = gap_ext + gap_len - W'(1);
        if (load) begin
            state_d = IDLE;
            gap_y_d = COORD_W'(GAP_START);
        end else if (state_q == IDLE) begin
            if (start) begin
                state_d = DOWN;
            end
        end else if (frame && move_en) begin
            if (gap_bot > W'(Y_BOT)) begin
                state_d = UP;
                gap_y_d = COORD_W'(W'(Y_BOT) - gap_len + W'(1));
            end else if (state_q == DOWN) begin
                if (gap_bot + W'(STEP) > W'(Y_BOT)) begin
                    state_d = UP;
                end else begin
                    gap_y_d = gap_y_q + COORD_W'(STEP);
                end
            end else begin
                if (gap_ext < W'(Y_TOP + STEP)) begin
                    state_d = DOWN;
                end else begin
                    gap_y_d = gap_y_q - COORD_W'(STEP);
                end
            end
        end
    end

    assign gap_y  = gap_y_q;
    assign dir_up = (state_q == UP);

endmodule

// File: rtl/gap_wall_gen.sv
// Vertical obstacle wall with a bouncing gap; registered per-pixel output.
// Define GAP_WALL_HIT_EN to add player_px/hit: a sticky collision flag that
// freezes gap motion until reset or load.
module gap_wall_gen
    import gap_wall_pkg::*;
#(
    parameter int unsigned COORD_W   = COORD_W_DEF,
    parameter int unsigned X_LEFT    = 208,
    parameter int unsigned WALL_W    = 9,
    parameter int unsigned Y_TOP     = 10,
    parameter int unsigned Y_BOT     = 470,
    parameter int unsigned GAP_START = 150,
    parameter int unsigned MIN_GAP   = 16,
    parameter int unsigned STEP      = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame,
    input  logic               start,
    input  logic               load,
    input  logic               run,
    input  logic               flash,
    input  logic [2:0]         gap_sel,
    input  logic [COORD_W-1:0] px,
    input  logic [COORD_W-1:0] py,
    output logic               wall,
    output logic               wall_raw,
    output logic [COORD_W-1:0] gap_y,
    output logic               dir_up
`ifdef GAP_WALL_HIT_EN
    ,
    input  logic               player_px,
    output logic               hit
`endif
);

    localparam int unsigned W = COORD_W + 1;

    logic [W-1:0] gap_len;
    logic [W-1:0] px_ext, py_ext, gy_ext;
    logic         in_col, in_rows, in_gap, raw_term;
    logic         wall_q, wall_d;
    logic         wall_raw_q, wall_raw_d;
    logic         move_en;

    gap_motion_fsm #(
        .COORD_W   (COORD_W),
        .Y_TOP     (Y_TOP),
        .Y_BOT     (Y_BOT),
        .GAP_START (GAP_START),
        .STEP      (STEP)
    ) u_motion (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .start   (start),
        .frame   (frame),
        .move_en (move_en),
        .gap_len (gap_len),
        .gap_y   (gap_y),
        .dir_up  (dir_up)
    );

    // Pixel compare against the current gap window.
    always_comb begin
        gap_len    = W'(MIN_GAP) + W'({gap_sel, 5'b0_0000});
        px_ext     = {1'b0, px};
        py_ext     = {1'b0, py};
        gy_ext     = {1'b0, gap_y};
        in_col     = (px_ext >= W'(X_LEFT)) && (px_ext <= W'(X_LEFT + WALL_W - 1));
        in_rows    = (py_ext >= W'(Y_TOP)) && (py_ext <= W'(Y_BOT));
        in_gap     = (py_ext >= gy_ext) && (py_ext <= gy_ext + gap_len - W'(1));
        raw_term   = in_col && in_rows && !in_gap;
        wall_raw_d = raw_term;
        wall_d     = raw_term && (run || flash);
    end

    // Pixel output registers (one cycle behind px/py).
    always_ff @(posedge clk) begin
        if (reset) begin
            wall_q     <= 1'b0;
            wall_raw_q <= 1'b0;
        end else begin
            wall_q     <= wall_d;
            wall_raw_q <= wall_raw_d;
        end
    end

    assign wall     = wall_q;
    assign wall_raw = wall_raw_q;

`ifdef GAP_WALL_HIT_EN
    logic hit_q, hit_d;

    // Sticky collision flag; load clears it along with the gap.
    always_comb begin
        hit_d = hit_q;
        if (load) begin
            hit_d = 1'b0;
        end else if (raw_term && player_px) begin
            hit_d = 1'b1;
        end
    end

    // Collision flag register.
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_q <= 1'b0;
        end else begin
            hit_q <= hit_d;
        end
    end

    assign hit     = hit_q;
    assign move_en = run && !hit_q;
`else
    assign move_en = run;
`endif

endmodule

// File: tb/tb_gap_wall_gen.sv
// Directed bench for gap_wall_gen (default parameters, optional hit disabled).
module tb_gap_wall_gen;

    logic       clk = 1'b0;
    logic       reset, frame, start, load, run, flash;
    logic [2:0] gap_sel;
    logic [9:0] px, py;
    logic       wall, wall_raw, dir_up;
    logic [9:0] gap_y;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    gap_wall_gen dut (
        .clk      (clk),
        .reset    (reset),
        .frame    (frame),
        .start    (start),
        .load     (load),
        .run      (run),
        .flash    (flash),
        .gap_sel  (gap_sel),
        .px       (px),
        .py       (py),
        .wall     (wall),
        .wall_raw (wall_raw),
        .gap_y    (gap_y),
        .dir_up   (dir_up)
    );

    typedef struct {
        logic [9:0] px;
        logic [9:0] py;
        logic       run;
        logic       flash;
        logic       exp_wall;
        logic       exp_raw;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            frame = 1'b1;
            tick();
            frame = 1'b0;
            tick();
        end
    endtask

    task automatic check_pos(input string name, input int exp_y, input int exp_up);
        check({name, ".gap_y"}, int'(gap_y), exp_y);
        check({name, ".dir_up"}, int'(dir_up), exp_up);
    endtask

    initial begin
        vecs[0]  = '{10'd210, 10'd149, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[1]  = '{10'd210, 10'd150, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{10'd210, 10'd229, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{10'd210, 10'd230, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[4]  = '{10'd207, 10'd300, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{10'd217, 10'd300, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{10'd208, 10'd300, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[7]  = '{10'd216, 10'd300, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[8]  = '{10'd210, 10'd9,   1'b1, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{10'd210, 10'd10,  1'b1, 1'b0, 1'b1, 1'b1};
        vecs[10] = '{10'd210, 10'd470, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[11] = '{10'd210, 10'd471, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{10'd210, 10'd300, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[13] = '{10'd210, 10'd300, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[14] = '{10'd210, 10'd149, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[15] = '{10'd210, 10'd200, 1'b0, 1'b1, 1'b0, 1'b0};

        reset = 1'b1; frame = 1'b0; start = 1'b0; load = 1'b0;
        run = 1'b1; flash = 1'b0; gap_sel = 3'd0;
        px = 10'd210; py = 10'd300;
        tick();
        tick();
        check_pos("reset", 150, 0);
        check("reset.wall", int'(wall), 0);
        check("reset.wall_raw", int'(wall_raw), 0);
        reset = 1'b0;

        // Frame in IDLE does not move; start together with frame only leaves IDLE.
        frames(1);
        check_pos("idle_frame", 150, 0);
        start = 1'b1; frame = 1'b1;
        tick();
        start = 1'b0; frame = 1'b0;
        tick();
        check_pos("start_frame", 150, 0);

        frames(10);
        check_pos("ten_frames", 160, 0);

        // Bottom bounce with gap_len 16.
        frames(295);
        check_pos("bottom_stop", 455, 0);
        frames(1);
        check_pos("bottom_turn", 455, 1);
        frames(1);
        check_pos("bottom_up", 454, 1);

        // Top bounce.
        frames(444);
        check_pos("top_reach", 10, 1);
        frames(1);
        check_pos("top_turn", 10, 0);
        frames(1);
        check_pos("top_down", 11, 0);

        // Frozen with run=0; wall follows flash, raw stays set.
        run = 1'b0;
        px = 10'd210; py = 10'd300;
        for (int i = 0; i < 6; i++) begin
            flash = (i % 2) ? 1'b1 : 1'b0;
            frame = 1'b1;
            tick();
            frame = 1'b0;
            check("frozen.wall", int'(wall), i % 2);
            check("frozen.wall_raw", int'(wall_raw), 1);
        end
        check_pos("frozen", 11, 0);
        run = 1'b1; flash = 1'b0;

        // Widening the gap past the bottom clamps it and turns upward.
        frames(229);
        check_pos("pre_clamp", 240, 0);
        gap_sel = 3'd7;
        frames(1);
        check_pos("clamp", 231, 1);
        frames(1);
        check_pos("after_clamp", 230, 1);
        gap_sel = 3'd0;

        // Reset mid-motion.
        px = 10'd210; py = 10'd300;
        tick();
        check("pre_reset.wall", int'(wall), 1);
        reset = 1'b1;
        tick();
        check_pos("mid_reset", 150, 0);
        check("mid_reset.wall", int'(wall), 0);
        check("mid_reset.wall_raw", int'(wall_raw), 0);
        reset = 1'b0;

        // Load and frame together while moving down.
        start = 1'b1;
        tick();
        start = 1'b0;
        frames(150);
        check_pos("down_300", 300, 0);
        load = 1'b1; frame = 1'b1;
        tick();
        load = 1'b0; frame = 1'b0;
        check_pos("load_frame", 150, 0);
        frames(3);
        check_pos("load_idle", 150, 0);

        // Pixel table at gap_y=150, gap_len=80.
        gap_sel = 3'd2;
        for (int i = 0; i < 16; i++) begin
            px = vecs[i].px;
            py = vecs[i].py;
            run = vecs[i].run;
            flash = vecs[i].flash;
            tick();
            check($sformatf("pix%0d.wall", i), int'(wall), int'(vecs[i].exp_wall));
            check($sformatf("pix%0d.wall_raw", i), int'(wall_raw), int'(vecs[i].exp_raw));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
